// File: rtl/p2m_gray_counter_dispatch.sv
// rtl/p2m_gray_counter_dispatch.sv - pipe-to-method dispatcher for GrayCounter with buffered read responses
module p2m_gray_counter_dispatch #(
    parameter int width      = 4,
    parameter int RESP_DEPTH = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               pipe_enq__ENA,
    input  logic [127:0]       pipe_enq_v,
    output logic               pipe_enq__RDY,
    output logic               method_decrement__ENA,
    input  logic               method_decrement__RDY,
    output logic               method_increment__ENA,
    input  logic               method_increment__RDY,
    input  logic [width-1:0]   method_readBin,
    input  logic               method_readBin__RDY,
    input  logic [width-1:0]   method_readGray,
    input  logic               method_readGray__RDY,
    output logic               method_writeBin__ENA,
    output logic [width-1:0]   method_writeBin_v,
    input  logic               method_writeBin__RDY,
    output logic               method_writeGray__ENA,
    output logic [width-1:0]   method_writeGray_v,
    input  logic               method_writeGray__RDY,
    output logic               returnInd_enq__ENA,
    output logic [127:0]       returnInd_enq_v,
    input  logic               returnInd_enq__RDY,
    output logic [15:0]        errCount
);
    localparam int AW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    logic               sv_q, sv_d;
    logic [15:0]        id_q, id_d;
    logic [width-1:0]   pay_q, pay_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]        cnt_q, cnt_d;
    logic [15:0]        err_cnt_q, err_cnt_d;
    logic [127:0]       mem_q [RESP_DEPTH];

    logic               full, empty, pop, push, fire, accept;
    logic               known, is_read, tgt_rdy;
    logic [width-1:0]   rd_val;
    logic [127:0]       resp_word;
    logic               unused_v;

    assign unused_v = ^pipe_enq_v;

    always_comb begin
        known   = 1'b1;
        is_read = 1'b0;
        tgt_rdy = 1'b0;
        rd_val  = '0;
        case (id_q)
            16'd0: tgt_rdy = method_decrement__RDY;
            16'd1: tgt_rdy = method_increment__RDY;
            16'd2: begin
                tgt_rdy = method_readBin__RDY;
                rd_val  = method_readBin;
                is_read = 1'b1;
            end
            16'd3: begin
                tgt_rdy = method_readGray__RDY;
                rd_val  = method_readGray;
                is_read = 1'b1;
            end
            16'd4: tgt_rdy = method_writeBin__RDY;
            16'd5: tgt_rdy = method_writeGray__RDY;
            default: known = 1'b0;
        endcase

        full  = (cnt_q == (AW+1)'(RESP_DEPTH));
        empty = (cnt_q == '0);
        pop   = !empty && returnInd_enq__RDY;
        // A full FIFO still takes a read if the head leaves in the same cycle
        fire  = sv_q && (!known || (tgt_rdy && (!is_read || !full || pop)));
        push  = fire && is_read;

        pipe_enq__RDY = !sv_q || fire;
        accept        = pipe_enq__ENA && pipe_enq__RDY;

        method_decrement__ENA = fire && (id_q == 16'd0);
        method_increment__ENA = fire && (id_q == 16'd1);
        method_writeBin__ENA  = fire && (id_q == 16'd4);
        method_writeGray__ENA = fire && (id_q == 16'd5);
        method_writeBin_v     = pay_q;
        method_writeGray_v    = pay_q;

        returnInd_enq__ENA = pop;
        returnInd_enq_v    = empty ? '0 : mem_q[rd_ptr_q];
        errCount           = err_cnt_q;

        resp_word              = '0;
        resp_word[31:16]       = id_q;
        resp_word[32 +: width] = rd_val;

        sv_d  = sv_q && !fire;
        id_d  = id_q;
        pay_d = pay_q;
        if (accept) begin
            sv_d  = 1'b1;
            id_d  = pipe_enq_v[31:16];
            pay_d = pipe_enq_v[32 +: width];
        end

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

        err_cnt_d = err_cnt_q;
        if (fire && !known && (err_cnt_q != 16'hFFFF))
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sv_q      <= 1'b0;
            id_q      <= '0;
            pay_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            sv_q      <= sv_d;
            id_q      <= id_d;
            pay_q     <= pay_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Entry contents need no reset: the head is masked to zero while empty
    always_ff @(posedge CLK) begin
        if (push)
            mem_q[wr_ptr_q] <= resp_word;
    end
endmodule
